// File: rtl/image_header_capture_pkg.sv
// Shared definitions for the image header capture block.
// Holds the stream word-type codes, the minimum header size a terminal
// emits, and a helper that classifies header-class word types.
package image_header_capture_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_START   = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_END     = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 4'h5;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 4'h8;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 4'h9;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = 4'hA;

    // Smallest header a terminal ever emits; a bank must hold at least this.
    localparam int IMAGE_IMAGE_DATA = 8;

    function automatic logic is_header_class(input logic [DTYPE_WIDTH-1:0] dtype);
        return (dtype == DTYPE_HEADER_START) || (dtype == DTYPE_HEADER) ||
               (dtype == DTYPE_HEADER_END);
    endfunction

endpackage

// File: rtl/image_header_capture_if.sv
// Image stream bundle: valid, word type and data word.
//   dv    : word valid
//   dtype : word type code
//   data  : word payload
// master drives the stream, slave receives it.
interface image_header_capture_if #(
    parameter int DATA_WIDTH = 16
) ();
    import image_header_capture_pkg::*;

    logic                   dv;
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [DATA_WIDTH-1:0]  data;

    modport master (output dv, output dtype, output data);
    modport slave  (input  dv, input  dtype, input  data);

endinterface

// File: rtl/image_header_capture_ram.sv
// Two-bank header store: simple dual-port RAM of 2*HEADER_DEPTH words.
//   clk          : clock
//   we/wbank/waddr/wdata : write port, bank-relative address
//   rbank/raddr  : read address, bank-relative
//   rdata        : registered read data (one cycle after the address)
// No reset on the array or read register so it maps onto block RAM.
module image_header_capture_ram #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 7,
    parameter int HEADER_DEPTH = 128
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  wbank,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rbank,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2*HEADER_DEPTH];

    // Bank 1 starts at HEADER_DEPTH so non-power-of-two depths pack tightly.
    function automatic logic [ADDR_WIDTH:0] bank_index(input logic bank,
                                                       input logic [ADDR_WIDTH-1:0] addr);
        return bank ? ((ADDR_WIDTH+1)'(HEADER_DEPTH) + {1'b0, addr}) : {1'b0, addr};
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem[bank_index(wbank, waddr)] <= wdata;
        end
        rdata <= mem[bank_index(rbank, raddr)];
    end

endmodule

// File: rtl/image_header_capture.sv
// Captures frame headers from an image stream into a double-buffered RAM
// and publishes each one atomically when its HEADER_END arrives.  The
// stream is forwarded with one cycle of latency, optionally with the
// header words removed.
//   clk, resetb  : clock, synchronous active-low reset
//   enable       : capture on; when low only the registered pass-through runs
//   strip        : drop header-class words from the forwarded stream
//   rx / tx      : input / output image stream
//   hdr_addr     : read address into the published header
//   hdr_data     : read data, one cycle after hdr_addr
//   hdr_len      : word count of the published header
//   hdr_valid    : a header has been published since reset
//   hdr_new      : one-cycle pulse after each publish
//   hdr_overflow : sticky, a header exceeded HEADER_DEPTH
//   hdr_abort    : sticky, a capture ended without HEADER_END
//   hdr_clear    : clears both sticky flags (wins over a set)
module image_header_capture
    import image_header_capture_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 7,
    parameter int HEADER_DEPTH = 128
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    strip,
    image_header_capture_if.slave   rx,
    image_header_capture_if.master  tx,
    input  logic [ADDR_WIDTH-1:0]   hdr_addr,
    output logic [DATA_WIDTH-1:0]   hdr_data,
    output logic [ADDR_WIDTH:0]     hdr_len,
    output logic                    hdr_valid,
    output logic                    hdr_new,
    output logic                    hdr_overflow,
    output logic                    hdr_abort,
    input  logic                    hdr_clear
);

    if ((HEADER_DEPTH > 2**ADDR_WIDTH) || (HEADER_DEPTH < IMAGE_IMAGE_DATA)) begin : g_depth_check
        $error("HEADER_DEPTH out of range for ADDR_WIDTH");
    end

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } cap_state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(HEADER_DEPTH);

    cap_state_t              state;
    logic [ADDR_WIDTH:0]     wptr;
    logic                    front;
    logic                    pass;
    logic                    cap_evt;
    logic                    room;
    logic                    wr_en;
    logic                    ovf_set;
    logic                    abort_set;
    logic                    publish;
    logic                    rd_ok_p1;
    logic [DATA_WIDTH-1:0]   ram_q_p1;

    // Only enabled, valid words seen while capturing drive header events.
    assign pass      = rx.dv & ~(enable & strip & is_header_class(rx.dtype));
    assign cap_evt   = enable & rx.dv & (state == ST_CAPTURE);
    assign room      = (wptr < DEPTH);
    assign wr_en     = cap_evt & (rx.dtype == DTYPE_HEADER) & room;
    assign ovf_set   = cap_evt & (rx.dtype == DTYPE_HEADER) & ~room;
    assign publish   = cap_evt & (rx.dtype == DTYPE_HEADER_END);
    assign abort_set = cap_evt & ((rx.dtype == DTYPE_HEADER_START) |
                                  (rx.dtype == DTYPE_FRAME_START));

    // Stream stage p0 -> p1: forwarded word, zeroed whenever it is not valid.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            tx.dv    <= 1'b0;
            tx.dtype <= '0;
            tx.data  <= '0;
        end else begin
            tx.dv    <= pass;
            tx.dtype <= pass ? rx.dtype : '0;
            tx.data  <= pass ? rx.data  : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state        <= ST_IDLE;
            wptr         <= '0;
            front        <= 1'b0;
            hdr_len      <= '0;
            hdr_valid    <= 1'b0;
            hdr_new      <= 1'b0;
            hdr_overflow <= 1'b0;
            hdr_abort    <= 1'b0;
        end else begin
            hdr_new      <= publish;
            hdr_overflow <= ~hdr_clear & (hdr_overflow | ovf_set);
            hdr_abort    <= ~hdr_clear & (hdr_abort | abort_set);

            // Disabling drops a partial capture silently; the published bank stays.
            if (!enable) begin
                state <= ST_IDLE;
            end else if (rx.dv) begin
                case (state)
                    ST_IDLE: begin
                        if (rx.dtype == DTYPE_HEADER_START) begin
                            state <= ST_CAPTURE;
                            wptr  <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        case (rx.dtype)
                            DTYPE_HEADER_START: wptr <= '0;
                            DTYPE_HEADER: begin
                                if (room) begin
                                    wptr <= wptr + (ADDR_WIDTH+1)'(1);
                                end
                            end
                            DTYPE_HEADER_END: begin
                                // Swapping banks makes the whole header visible at once.
                                front     <= ~front;
                                hdr_len   <= wptr;
                                hdr_valid <= 1'b1;
                                state     <= ST_IDLE;
                            end
                            DTYPE_FRAME_START: state <= ST_IDLE;
                            default: ;
                        endcase
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read stage p0 -> p1: bank select and length are sampled with the address,
    // so a read on the publish edge still sees the old header.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            rd_ok_p1 <= 1'b0;
        end else begin
            rd_ok_p1 <= ({1'b0, hdr_addr} < hdr_len);
        end
    end

    assign hdr_data = rd_ok_p1 ? ram_q_p1 : '0;

    image_header_capture_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .HEADER_DEPTH (HEADER_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .wbank (~front),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (rx.data),
        .rbank (front),
        .raddr (hdr_addr),
        .rdata (ram_q_p1)
    );

endmodule

// File: doc/image_header_capture.md
Name: image_header_capture

Overview:
- Receive-side counterpart of the header-delaying stage. Sits downstream on the dvi/dtype/data image stream, ahead of any consumer that needs the frame header as random-access data (ancillary decode, register mirror, host readback).
- Captures each header into a double-buffered RAM and publishes it atomically at header end.
- Forwards the stream with 1-cycle latency and can optionally strip header words from it.

Parameters:
- DATA_WIDTH, 16, width of datai/datao/hdr_data.
- ADDR_WIDTH, 7, width of hdr_addr and hdr_len; bank index width.
- HEADER_DEPTH, 128, words per bank; must be ≤ 2**ADDR_WIDTH and ≥ `Image_image_data.

Ports:
- clk  in  1  single clock.
- resetb  in  1  synchronous reset, active low.
- enable  in  1  1 = capture active; 0 = registered pass-through only.
- strip  in  1  1 = remove header-class words from the output stream.
- dvi  in  1  input data valid.
- dtypei  in  `DTYPE_WIDTH  input word type.
- datai  in  DATA_WIDTH  input word.
- dvo  out  1  output valid.
- dtypeo  out  `DTYPE_WIDTH  output type.
- datao  out  DATA_WIDTH  output word.
- hdr_addr  in  ADDR_WIDTH  read address into the published header.
- hdr_data  out  DATA_WIDTH  registered read data.
- hdr_len  out  ADDR_WIDTH+1  word count of the published header.
- hdr_valid  out  1  a header has been published since reset.
- hdr_new  out  1  1-cycle pulse on publish.
- hdr_overflow  out  1  sticky; set when a header exceeds HEADER_DEPTH.
- hdr_abort  out  1  sticky; set when a capture ends without `DTYPE_HEADER_END.
- hdr_clear  in  1  clears hdr_overflow and hdr_abort.

Behaviour:
- Reset (resetb=0 at a clk edge): all outputs 0. FSM=IDLE, wptr=0, front bank=0. RAM contents are don't-care.
- Stream path:
  - Registered, latency 1: dvo/dtypeo/datao on cycle N+1 = dvi/dtypei/datai of cycle N.
  - When dvo would be 0, dtypeo and datao are driven 0.
  - When enable=1 and strip=1, words with dtypei ∈ {HEADER_START, HEADER, HEADER_END} output dvo=0, dtypeo=0, datao=0.
  - When enable=0, strip is ignored.
- FSM states: IDLE, CAPTURE. Only dvi=1 cycles are evaluated.
  - IDLE, HEADER_START → CAPTURE, wptr←0.
  - CAPTURE, `DTYPE_HEADER: if wptr<HEADER_DEPTH, write datai to back[wptr] and increment wptr. Otherwise drop the word and set hdr_overflow.
  - CAPTURE, HEADER_END → publish, then IDLE:
    - front←back
    - hdr_len←wptr
    - hdr_valid←1
    - hdr_new pulses on the next cycle
  - CAPTURE, HEADER_START → restart: wptr←0, stay CAPTURE, set hdr_abort, no publish.
  - CAPTURE, FRAME_START → IDLE, set hdr_abort, no publish. The front bank is unchanged.
  - All other dtypes leave state unchanged.
- Overflowed header: still published at HEADER_END, with hdr_len=HEADER_DEPTH.
- Empty header (START immediately followed by END): publishes hdr_len=0 and hdr_new still pulses.
- Read port:
  - hdr_data(N+1) = front[hdr_addr(N)] when hdr_addr(N) < hdr_len; otherwise 0.
  - Address and length are sampled with the bank select at edge N.
  - A read issued on the publish edge returns old-bank data. The next cycle returns new-bank data.
- Sticky flags:
  - hdr_clear wins over a simultaneous set in the same cycle.
  - Flags persist across enable toggles.
- enable=0:
  - FSM forced to IDLE and any partial capture is discarded without setting hdr_abort.
  - hdr_valid, hdr_len and the front bank are retained; the read port stays functional.
- enable 0→1 mid-header: the words are ignored until the next HEADER_START.

Decomposition:
- The DTYPE codes and `DTYPE_WIDTH come from the shared dtypes include. `Image_image_data comes from the terminal defs include.
- FSM state encoding is a local constant pair in the block.
- One sub-module: image_header_capture_ram.
  - 2×HEADER_DEPTH × DATA_WIDTH simple dual-port RAM: write port {bank,wptr}, registered read port {bank,addr}.
  - Chosen so the RAM infers block RAM.

Test Plan:
- Basic capture: HEADER_START, 5 HEADER words 0x1111..0x5555, HEADER_END, enable=1, strip=0 → hdr_new pulses once; hdr_len=5; hdr_addr=2 → hdr_data=0x3333 one cycle later; hdr_addr=7 → 0; all 7 words appear on dvo with 1-cycle latency.
- Strip: same stream with strip=1 → zero dvo cycles for the 7 header words; a following FRAME_START and 4 pixels pass with dvo=1, latency 1.
- Double buffer: publish header A (len 3), start header B, write 2 words, read addr 0 continuously → returns A[0] until the cycle after B's HEADER_END, then B[0]; a read on the publish edge returns A[0].
- Overflow: HEADER_DEPTH+3 HEADER words then END → hdr_overflow=1, hdr_len=128, addr 127 holds word 127; hdr_clear → flag 0 next cycle.
- Abort: HEADER_START, 2 words, FRAME_START → hdr_abort=1, no hdr_new, hdr_len and front bank keep the previous header; likewise HEADER_START twice sets abort and the second header publishes normally.
- Reset/enable: assert resetb=0 mid-CAPTURE → next cycle all outputs 0, hdr_valid=0; drop enable mid-header then raise it and send END → no publish, no abort.
